// File: rtl/cnt_event_monitor_if.sv
// Event-record stream between the counter monitor and its consumer.
// master = counter/consumer side (testbench or system), slave = cnt_event_monitor.
interface cnt_event_monitor_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cmp_val;
  logic             cmp_we;
  // Handshake: a record transfers on a rising edge where evt_valid && evt_ready.
  // evt_data is held stable while evt_valid=1 and evt_ready=0, and evt_valid
  // never depends combinationally on evt_ready.
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH+2:0] evt_data;
  logic             overflow;

  modport master (
    output cnt_in, cmp_val, cmp_we, evt_ready,
    input  evt_valid, evt_data, overflow
  );

  modport slave (
    input  cnt_in, cmp_val, cmp_we, evt_ready,
    output evt_valid, evt_data, overflow
  );
endinterface

// File: rtl/cnt_event_monitor.sv
// Watches a counter output, classifies each transition (match/wrap/jump) and
// queues one record per event in a show-ahead FIFO drained by valid/ready.
module cnt_event_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  cnt_event_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = WIDTH + 3;

  typedef logic [AW:0]   occ_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [RW-1:0] rec_t;

  localparam occ_t FULL_OCC = occ_t'(DEPTH);

  localparam logic [1:0] KIND_STEP = 2'b00;
  localparam logic [1:0] KIND_WRAP = 2'b01;
  localparam logic [1:0] KIND_JUMP = 2'b10;

  logic [WIDTH-1:0] cmp_reg;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_inc;
  logic             prev_ok;

  rec_t mem [DEPTH];
  ptr_t rd_ptr, wr_ptr, rd_ptr_nx;
  occ_t occ, occ_nx;

  logic evt_valid_r;
  rec_t evt_data_r;
  logic overflow_r;

  logic [1:0] kind;
  logic       match;
  logic       rec_gen;
  rec_t       rec;
  rec_t       head_nx;
  logic       full, push, pop, drop;

  assign prev_inc = prev + WIDTH'(1);

  always_comb begin
    kind  = KIND_STEP;
    match = 1'b0;
    if (prev_ok) begin
      if (bus.cnt_in == prev) begin
        kind = KIND_STEP;
      end else if (bus.cnt_in == prev_inc) begin
        kind = (&prev) ? KIND_WRAP : KIND_STEP;
      end else begin
        kind = KIND_JUMP;
      end
      // Entry-only match: a held count sitting on cmp_reg does not re-fire.
      match = (bus.cnt_in == cmp_reg) && (bus.cnt_in != prev);
    end
  end

  assign rec_gen = match || (kind != KIND_STEP);
  assign rec     = {match, kind, bus.cnt_in};

  assign full = (occ == FULL_OCC);
  assign pop  = evt_valid_r && bus.evt_ready;
  assign push = rec_gen && (!full || pop);
  assign drop = rec_gen && full && !pop;

  assign rd_ptr_nx = pop ? rd_ptr + ptr_t'(1) : rd_ptr;

  always_comb begin
    occ_nx = occ;
    case ({push, pop})
      2'b10:   occ_nx = occ + occ_t'(1);
      2'b01:   occ_nx = occ - occ_t'(1);
      default: occ_nx = occ;
    endcase
  end

  // The next head is the incoming record when it lands exactly in the slot
  // the read pointer moves to (empty FIFO, or draining the last entry).
  assign head_nx = (push && (rd_ptr_nx == wr_ptr)) ? rec : mem[rd_ptr_nx];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_reg     <= '0;
      prev        <= '0;
      prev_ok     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      evt_valid_r <= 1'b0;
      evt_data_r  <= '0;
      overflow_r  <= 1'b0;
    end else begin
      prev    <= bus.cnt_in;
      prev_ok <= 1'b1;
      if (bus.cmp_we) begin
        cmp_reg <= bus.cmp_val;
      end
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      rd_ptr      <= rd_ptr_nx;
      occ         <= occ_nx;
      evt_valid_r <= (occ_nx != '0);
      if (occ_nx != '0) begin
        evt_data_r <= head_nx;
      end
      if (drop) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_data  = evt_data_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_cnt_event_monitor.sv
// Self-checking bench for cnt_event_monitor: reference model of the event
// classifier feeding an expected-record queue, compared on each handshake.
module tb_cnt_event_monitor;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int RW    = WIDTH + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cnt_event_monitor_if #(.WIDTH(WIDTH)) bus ();

  cnt_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int               checks   = 0;
  int               failures = 0;
  int               n_pop    = 0;
  logic [RW-1:0]    exp_q[$];
  logic             exp_ovf;
  logic [WIDTH-1:0] m_prev;
  logic [WIDTH-1:0] m_cmp;
  logic             m_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.cmp_we = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    m_prev  = '0;
    m_cmp   = '0;
    m_ok    = 1'b0;
  endtask

  // Drives one counter sample, checks the handshake that completes on the
  // coming edge, and predicts the record that edge generates.
  task automatic step(input logic [WIDTH-1:0] c, input logic we = 1'b0,
                      input logic [WIDTH-1:0] cv = '0);
    logic [WIDTH-1:0] diff;
    logic [1:0]       k;
    logic             mt;
    bus.cnt_in  = c;
    bus.cmp_we  = we;
    bus.cmp_val = cv;
    check("evt_valid", 32'(bus.evt_valid), 32'(exp_q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    if (bus.evt_valid && bus.evt_ready && exp_q.size() != 0) begin
      check("evt_data", 32'(bus.evt_data), 32'(exp_q.pop_front()));
      n_pop++;
    end
    k  = 2'b00;
    mt = 1'b0;
    diff = '0;
    if (m_ok) begin
      diff = c - m_prev;
      if (diff == '0)           k = 2'b00;
      else if (diff == WIDTH'(1)) k = (c == '0) ? 2'b01 : 2'b00;
      else                      k = 2'b10;
      mt = (c == m_cmp) && (diff != '0);
    end
    if (mt || k != 2'b00) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({mt, k, c});
      else exp_ovf = 1'b1;
    end
    m_prev = c;
    m_ok   = 1'b1;
    if (we) m_cmp = cv;
    @(posedge clk);
    #1;
    bus.cmp_we = 1'b0;
  endtask

  initial begin
    bus.cnt_in    = '0;
    bus.cmp_val   = '0;
    bus.cmp_we    = 1'b0;
    bus.evt_ready = 1'b1;
    do_reset();
    check("rst_valid", 32'(bus.evt_valid), 32'h0);
    check("rst_data", 32'(bus.evt_data), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);

    // Compare match while free-running from 0
    step(8'd0, 1'b1, 8'd10);
    for (int i = 1; i <= 10; i++) step(WIDTH'(i));
    check("match_valid", 32'(bus.evt_valid), 32'h1);
    check("match_rec", 32'(bus.evt_data), 32'h40A);
    n_pop = 0;
    for (int i = 11; i <= 255; i++) step(WIDTH'(i));
    check("match_only_one", 32'(n_pop), 32'd1);

    // Wrap-around with cmp_reg=200
    step(8'd255, 1'b1, 8'd200);
    step(8'd254);
    step(8'd255);
    step(8'd0);
    check("wrap_rec", 32'(bus.evt_data), 32'h100);

    // Jump / load, then jump landing on the compare value
    step(8'd40);
    step(8'd55);
    check("jump_rec", 32'(bus.evt_data), 32'h237);
    step(8'd40, 1'b1, 8'd55);
    step(8'd55);
    check("jump_match_rec", 32'(bus.evt_data), 32'h637);

    // Hold on the compare value: entry fires once, then silence
    step(8'd10, 1'b1, 8'd10);
    step(8'd11);
    step(8'd10);
    check("hold_entry", 32'(bus.evt_data), 32'h60A);
    repeat (20) step(8'd10);
    check("hold_idle", 32'(bus.evt_valid), 32'h0);

    // Overflow: five jumps into a stalled four-deep FIFO
    bus.evt_ready = 1'b0;
    step(8'd1);
    step(8'd3);
    step(8'd5);
    step(8'd7);
    step(8'd9);
    check("ovf_set", 32'(bus.overflow), 32'h1);
    check("ovf_head", 32'(bus.evt_data), 32'h201);
    bus.evt_ready = 1'b1;
    n_pop = 0;
    repeat (6) step(8'd9);
    check("ovf_drain_cnt", 32'(n_pop), 32'd4);
    check("ovf_drained", 32'(bus.evt_valid), 32'h0);
    check("ovf_sticky", 32'(bus.overflow), 32'h1);

    // Full FIFO with simultaneous pop and push
    do_reset();
    check("rst2_ovf", 32'(bus.overflow), 32'h0);
    step(8'd0);
    bus.evt_ready = 1'b0;
    step(8'd2);
    step(8'd4);
    step(8'd6);
    step(8'd8);
    check("full_valid", 32'(bus.evt_valid), 32'h1);
    bus.evt_ready = 1'b1;
    step(8'd12);
    check("pp_ovf", 32'(bus.overflow), 32'h0);
    n_pop = 0;
    repeat (5) step(8'd12);
    check("pp_occupancy", 32'(n_pop), 32'd4);

    // Reset with records queued, then a jump on the first post-reset clock
    bus.evt_ready = 1'b0;
    step(8'd20);
    step(8'd30);
    step(8'd40);
    check("pre_rst_valid", 32'(bus.evt_valid), 32'h1);
    do_reset();
    check("rst_mid_valid", 32'(bus.evt_valid), 32'h0);
    step(8'd99);
    check("post_rst_norec", 32'(bus.evt_valid), 32'h0);
    bus.evt_ready = 1'b1;
    step(8'd50);
    check("post_rst_rec", 32'(bus.evt_data), 32'h232);
    step(8'd50);
    step(8'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
